// File: rtl/decode_mon_pkg.sv
// Legal decoder codes, monitor FSM states and the word classifier shared by
// the decode word monitor and its histogram bank.
package decode_mon_pkg;

    localparam int NUM_IDX = 8;

    localparam logic [31:0] CODE_IDX0    = 32'd11111110;
    localparam logic [31:0] CODE_IDX1    = 32'd11111101;
    localparam logic [31:0] CODE_IDX2    = 32'd11111011;
    localparam logic [31:0] CODE_IDX3    = 32'd11110111;
    localparam logic [31:0] CODE_IDX4    = 32'd11101111;
    localparam logic [31:0] CODE_IDX5    = 32'd11011111;
    localparam logic [31:0] CODE_IDX6    = 32'd10111111;
    localparam logic [31:0] CODE_IDX7    = 32'd01111111;
    localparam logic [31:0] CODE_IDLE_LO = 32'd0;
    localparam logic [31:0] CODE_IDLE_HI = 32'd11111111;

    typedef enum logic [1:0] {IDLE, RUN, SNAP} state_t;

    typedef struct packed {
        logic       legal;
        logic       idle;
        logic [2:0] idx;
    } code_info_t;

    function automatic code_info_t code_to_idx(input logic [31:0] word);
        code_info_t info;
        info.legal = 1'b1;
        info.idle  = 1'b0;
        info.idx   = 3'd0;
        case (word)
            CODE_IDX0: info.idx = 3'd0;
            CODE_IDX1: info.idx = 3'd1;
            CODE_IDX2: info.idx = 3'd2;
            CODE_IDX3: info.idx = 3'd3;
            CODE_IDX4: info.idx = 3'd4;
            CODE_IDX5: info.idx = 3'd5;
            CODE_IDX6: info.idx = 3'd6;
            CODE_IDX7: info.idx = 3'd7;
            CODE_IDLE_LO, CODE_IDLE_HI: begin
                info.legal = 1'b0;
                info.idle  = 1'b1;
            end
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/decode_mon_hist.sv
// Eight saturating live hit counters, the snapshot bank of the last completed
// window and a registered read port into that bank.
module decode_mon_hist
    import decode_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [2:0]       idx,
    input  logic             snap,
    input  logic             clr,
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] count
);

    logic [NUM_IDX-1:0][CNT_W-1:0] live;
    logic [NUM_IDX-1:0][CNT_W-1:0] bank;

    always_ff @(negedge clk) begin
        if (rst) begin
            live  <= '0;
            bank  <= '0;
            count <= '0;
        end else begin
            count <= bank[sel];
            if (snap && !clr)
                bank <= live;
            // On a snapshot cycle the live set restarts, seeded with the incoming hit.
            for (int i = 0; i < NUM_IDX; i++) begin
                if (clr)
                    live[i] <= '0;
                else if (inc && idx == 3'(i))
                    live[i] <= snap ? CNT_W'(1) : ((&live[i]) ? live[i] : live[i] + 1'b1);
                else if (snap)
                    live[i] <= '0;
            end
        end
    end

endmodule

// File: rtl/decode_word_monitor.sv
// Registers decoded words, recovers their index, flags illegal codes and
// gathers per-index histograms over fixed sample windows.
module decode_word_monitor
    import decode_mon_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             clr,
    output logic [2:0]       idx_out,
    output logic             idx_valid,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    input  logic [2:0]       hist_sel,
    output logic [CNT_W-1:0] hist_count,
    output logic             window_done
);

    localparam int WIN_W = $clog2(WINDOW);

    logic [WIDTH-1:0] s1_data;
    logic             s1_en;
    code_info_t       info;
    logic             take;
    logic             hit;
    logic             miss;
    state_t           state;
    state_t           state_next;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_next;
    logic             snap;

    always_ff @(negedge clk) begin
        if (rst) begin
            s1_data <= '0;
            s1_en   <= 1'b0;
        end else begin
            s1_data <= data_in;
            s1_en   <= en;
        end
    end

    // A stage-2 sample coincident with clr is dropped before it touches any counter.
    always_comb begin
        info = code_to_idx(32'(s1_data));
        take = s1_en && !clr;
        hit  = take && info.legal;
        miss = take && !info.legal && !info.idle;
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state   <= IDLE;
            win_cnt <= '0;
        end else begin
            state   <= state_next;
            win_cnt <= win_next;
        end
    end

    always_comb begin
        state_next = state;
        win_next   = win_cnt;
        snap       = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next = RUN;
                    win_next   = WIN_W'(1);
                end
            end
            RUN: begin
                if (take) begin
                    if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        state_next = SNAP;
                        win_next   = '0;
                    end else begin
                        win_next = win_cnt + 1'b1;
                    end
                end
            end
            SNAP: begin
                snap       = 1'b1;
                state_next = RUN;
                win_next   = take ? WIN_W'(1) : '0;
            end
            default: state_next = IDLE;
        endcase
        // clr overrides a pending window end: no snapshot is taken.
        if (clr) begin
            snap     = 1'b0;
            win_next = '0;
            if (state == SNAP)
                state_next = RUN;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            idx_out     <= '0;
            idx_valid   <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            window_done <= 1'b0;
        end else begin
            idx_valid   <= hit;
            err         <= miss;
            window_done <= snap;
            if (hit)
                idx_out <= info.idx;
            if (clr)
                err_count <= '0;
            else if (miss && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

    decode_mon_hist #(
        .CNT_W (CNT_W)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .idx   (info.idx),
        .snap  (snap),
        .clr   (clr),
        .sel   (hist_sel),
        .count (hist_count)
    );

endmodule
